// File: rtl/scoreboard_hazard_unit.sv
// scoreboard_hazard_unit: per-register countdown scoreboard driving ID stalls, EX bubbles, IF flush and a stall counter
module scoreboard_hazard_unit #(
  parameter int NUM_REGS   = 32,
  parameter int REG_AW     = 5,
  parameter int NUM_SRC    = 2,
  parameter int LAT_W      = 3,
  parameter bit FORWARD_EN = 1'b1,
  parameter int WB_LAT     = 3,
  parameter int PERF_W     = 32
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] i_id_src,
  input  logic [NUM_SRC-1:0]        i_id_src_used,
  input  logic [REG_AW-1:0]         i_id_rd,
  input  logic                      i_id_reg_write,
  input  logic [LAT_W-1:0]          i_id_lat,
  input  logic                      i_ext_stall,
  input  logic                      i_branch_mispredict,
  output logic                      o_stall_if,
  output logic                      o_stall_id,
  output logic                      o_bubble_ex,
  output logic                      o_flush_if,
  output logic                      o_fwd_en,
  output logic [NUM_SRC-1:0]        o_hazard_src,
  output logic [PERF_W-1:0]         o_stall_cycles
);
  logic [LAT_W-1:0]  cnt_q [NUM_REGS];
  logic [LAT_W-1:0]  cnt_d [NUM_REGS];
  logic [PERF_W-1:0] stall_ctr_q, stall_ctr_d;
  logic [LAT_W-1:0]  eff_lat;
  logic [NUM_SRC-1:0] hz;
  logic              waw, haz, issue;
  assign eff_lat = FORWARD_EN ? i_id_lat : LAT_W'(WB_LAT);
  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    logic [REG_AW-1:0] src;
    assign src   = i_id_src[k*REG_AW +: REG_AW];
    assign hz[k] = i_id_valid & i_id_src_used[k] & (|src) & (|cnt_q[src]);
  end
  // a younger writer may not land before an older in-flight one to the same register
  assign waw   = i_id_valid & i_id_reg_write & (|i_id_rd) & (cnt_q[i_id_rd] > eff_lat);
  assign haz   = (|hz) | waw;
  assign issue = i_id_valid & ~haz & ~i_ext_stall & ~i_branch_mispredict & ~i_rst;
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++)
      cnt_d[r] = i_ext_stall ? cnt_q[r] :
                 (issue & i_id_reg_write & (i_id_rd == REG_AW'(r)) & (r != 0)) ? eff_lat :
                 (|cnt_q[r]) ? cnt_q[r] - LAT_W'(1) : cnt_q[r];
    stall_ctr_d = (haz & ~i_branch_mispredict & ~i_ext_stall & ~(&stall_ctr_q)) ?
                  stall_ctr_q + PERF_W'(1) : stall_ctr_q;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q       <= '{default: '0};
      stall_ctr_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      stall_ctr_q <= stall_ctr_d;
    end
  end
  assign o_flush_if     = ~i_rst & i_branch_mispredict;
  assign o_bubble_ex    = ~i_rst & (i_branch_mispredict | (~i_ext_stall & haz));
  assign o_stall_if     = ~i_rst & ~i_branch_mispredict & (i_ext_stall | haz);
  assign o_stall_id     = o_stall_if;
  assign o_hazard_src   = i_rst ? '0 : hz;
  assign o_fwd_en       = FORWARD_EN;
  assign o_stall_cycles = stall_ctr_q;
endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// tb_scoreboard_hazard_unit: directed scenarios plus randomized run against a ready-time reference model
module tb_scoreboard_hazard_unit;
  logic clk = 1'b0;
  logic rst, id_valid, id_wr, ext, mp;
  logic [9:0] id_src;
  logic [1:0] used;
  logic [4:0] rd;
  logic [2:0] lat;
  logic s_if [3], s_id [3], bub [3], fl [3], fw [3];
  logic [1:0] hs [3];
  logic [31:0] sc0, sc1;
  logic [3:0] sc2;
  int n_cmp = 0, n_err = 0;
  longint tk [3];
  longint rdy [3][32];
  longint scm [3];
  longint scmax [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hF};

  always #5 clk = ~clk;

  scoreboard_hazard_unit u0 (.i_clk(clk), .i_rst(rst), .i_id_valid(id_valid), .i_id_src(id_src),
    .i_id_src_used(used), .i_id_rd(rd), .i_id_reg_write(id_wr), .i_id_lat(lat), .i_ext_stall(ext),
    .i_branch_mispredict(mp), .o_stall_if(s_if[0]), .o_stall_id(s_id[0]), .o_bubble_ex(bub[0]),
    .o_flush_if(fl[0]), .o_fwd_en(fw[0]), .o_hazard_src(hs[0]), .o_stall_cycles(sc0));
  scoreboard_hazard_unit #(.FORWARD_EN(1'b0), .WB_LAT(3)) u1 (.i_clk(clk), .i_rst(rst),
    .i_id_valid(id_valid), .i_id_src(id_src), .i_id_src_used(used), .i_id_rd(rd), .i_id_reg_write(id_wr),
    .i_id_lat(lat), .i_ext_stall(ext), .i_branch_mispredict(mp), .o_stall_if(s_if[1]), .o_stall_id(s_id[1]),
    .o_bubble_ex(bub[1]), .o_flush_if(fl[1]), .o_fwd_en(fw[1]), .o_hazard_src(hs[1]), .o_stall_cycles(sc1));
  scoreboard_hazard_unit #(.PERF_W(4)) u2 (.i_clk(clk), .i_rst(rst), .i_id_valid(id_valid),
    .i_id_src(id_src), .i_id_src_used(used), .i_id_rd(rd), .i_id_reg_write(id_wr), .i_id_lat(lat),
    .i_ext_stall(ext), .i_branch_mispredict(mp), .o_stall_if(s_if[2]), .o_stall_id(s_id[2]),
    .o_bubble_ex(bub[2]), .o_flush_if(fl[2]), .o_fwd_en(fw[2]), .o_hazard_src(hs[2]), .o_stall_cycles(sc2));

  // model: a register is pending until the non-frozen cycle count reaches its ready time
  function automatic longint pend(int i, int r);
    return (r == 0 || rdy[i][r] <= tk[i]) ? 0 : rdy[i][r] - tk[i];
  endfunction
  function automatic longint eff(int i);
    return (i == 1) ? 3 : longint'(lat);
  endfunction
  function automatic logic [1:0] mhz(int i);
    logic [1:0] h;
    for (int k = 0; k < 2; k++)
      h[k] = id_valid & used[k] & (pend(i, int'(id_src[k*5 +: 5])) > 0);
    return h;
  endfunction
  function automatic logic mhaz(int i);
    return (|mhz(i)) | (id_valid & id_wr & (pend(i, int'(rd)) > eff(i)));
  endfunction

  task automatic step();
    for (int i = 0; i < 3; i++) begin
      logic h;
      h = mhaz(i);
      if (rst) begin
        for (int r = 0; r < 32; r++) rdy[i][r] = tk[i];
        scm[i] = 0;
      end else begin
        if (!mp && !ext && h && scm[i] < scmax[i]) scm[i]++;
        if (!ext) begin
          if (id_valid && !h && !mp && id_wr && rd != 0) rdy[i][rd] = tk[i] + 1 + eff(i);
          tk[i]++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_src = '0; used = '0; rd = '0; id_wr = 0; lat = '0; ext = 0; mp = 0;
  endtask
  task automatic instr(input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] u,
                       input logic [4:0] d, input logic [2:0] l);
    id_valid = 1; id_src = {s1, s0}; used = u; rd = d; id_wr = 1; lat = l; ext = 0; mp = 0;
  endtask
  task automatic do_reset();
    idle(); rst = 1; step(); rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; instr(5'd1, 5'd2, 2'b11, 5'd3, 3'd2); ext = 1; mp = 1; #1;
    n_cmp++;
    if ({s_if[0], s_id[0], bub[0], fl[0], hs[0]} !== 6'b0) begin
      n_err++; $display("FAIL reset_outputs: got %b want 000000", {s_if[0], s_id[0], bub[0], fl[0], hs[0]});
    end
    step(); rst = 0; idle(); #1;
    n_cmp++;
    if (sc0 !== 32'd0 || sc2 !== 4'd0) begin n_err++; $display("FAIL reset_ctr: got %0d/%0d want 0/0", sc0, sc2); end
    n_cmp++;
    if (fw[0] !== 1'b1 || fw[1] !== 1'b0) begin n_err++; $display("FAIL fwd_en: got %b%b want 10", fw[0], fw[1]); end
  endtask

  task automatic test_load_use();
    do_reset(); instr(5'd0, 5'd0, 2'b00, 5'd5, 3'd1); #1;
    n_cmp++;
    if (s_id[0] !== 1'b0) begin n_err++; $display("FAIL lu_load_issue: stall %b want 0", s_id[0]); end
    step(); instr(5'd5, 5'd1, 2'b11, 5'd6, 3'd0); #1;
    n_cmp++;
    if ({s_id[0], bub[0], hs[0]} !== 4'b1101) begin
      n_err++; $display("FAIL lu_stall: got %b want 1101", {s_id[0], bub[0], hs[0]});
    end
    step();
    n_cmp++;
    if ({s_id[0], hs[0]} !== 3'b000 || sc0 !== 32'd1) begin
      n_err++; $display("FAIL lu_issue: stall/hs %b ctr %0d want 000/1", {s_id[0], hs[0]}, sc0);
    end
    step(); idle();
  endtask

  task automatic test_ext_div();
    int n = 0;
    do_reset(); instr(5'd0, 5'd0, 2'b00, 5'd7, 3'd5); step();
    instr(5'd7, 5'd0, 2'b01, 5'd8, 3'd0); ext = 1;
    repeat (3) begin
      #1; n_cmp++;
      if ({s_id[0], bub[0]} !== 2'b10) begin n_err++; $display("FAIL ext_freeze: got %b want 10", {s_id[0], bub[0]}); end
      step();
    end
    ext = 0; #1;
    while (s_id[0] && n < 20) begin n++; step(); end
    n_cmp++;
    if (n != 5 || sc0 !== 32'd5) begin n_err++; $display("FAIL div_stalls: got %0d ctr %0d want 5/5", n, sc0); end
    step(); idle();
  endtask

  task automatic test_waw();
    int n = 0;
    do_reset(); instr(5'd0, 5'd0, 2'b00, 5'd9, 3'd4); step();
    instr(5'd0, 5'd0, 2'b00, 5'd9, 3'd0); #1;
    while (s_id[0] && n < 20) begin n++; step(); end
    n_cmp++;
    if (n != 4) begin n_err++; $display("FAIL waw_stalls: got %0d want 4", n); end
    step(); instr(5'd9, 5'd9, 2'b11, 5'd10, 3'd0); #1;
    n_cmp++;
    if (s_id[0] !== 1'b0) begin n_err++; $display("FAIL waw_cleared: stall %b want 0", s_id[0]); end
    step(); idle();
  endtask

  task automatic test_mispredict();
    int n = 0;
    do_reset(); instr(5'd0, 5'd0, 2'b00, 5'd5, 3'd3); step();
    instr(5'd5, 5'd0, 2'b01, 5'd6, 3'd0); mp = 1; #1;
    n_cmp++;
    if ({fl[0], bub[0], s_if[0], s_id[0]} !== 4'b1100) begin
      n_err++; $display("FAIL mispredict: got %b want 1100", {fl[0], bub[0], s_if[0], s_id[0]});
    end
    step(); mp = 0; #1;
    while (s_id[0] && n < 20) begin n++; step(); end
    n_cmp++;
    if (n != 2) begin n_err++; $display("FAIL mp_countdown: got %0d want 2", n); end
    step(); idle();
  endtask

  task automatic test_no_forward();
    int n = 0;
    do_reset(); instr(5'd0, 5'd0, 2'b00, 5'd3, 3'd0); step();
    instr(5'd3, 5'd0, 2'b01, 5'd4, 3'd0); #1;
    n_cmp++;
    if (s_id[0] !== 1'b0) begin n_err++; $display("FAIL fwd_alu: stall %b want 0", s_id[0]); end
    while (s_id[1] && n < 20) begin n++; step(); end
    n_cmp++;
    if (n != 3) begin n_err++; $display("FAIL nofwd_stalls: got %0d want 3", n); end
    step(); instr(5'd0, 5'd0, 2'b00, 5'd0, 3'd7); step();
    instr(5'd0, 5'd0, 2'b11, 5'd1, 3'd0); #1;
    n_cmp++;
    if ({s_id[1], hs[1]} !== 3'b000) begin n_err++; $display("FAIL x0_src: got %b want 000", {s_id[1], hs[1]}); end
    step(); idle();
  endtask

  task automatic test_saturate();
    int n;
    do_reset();
    repeat (3) begin
      n = 0; instr(5'd0, 5'd0, 2'b00, 5'd4, 3'd7); step();
      instr(5'd4, 5'd0, 2'b01, 5'd5, 3'd0); #1;
      while (s_id[0] && n < 20) begin n++; step(); end
      step();
    end
    #1; n_cmp++;
    if (sc2 !== 4'hF || sc0 !== 32'd21) begin n_err++; $display("FAIL saturate: got %0h/%0d want f/21", sc2, sc0); end
    instr(5'd0, 5'd0, 2'b00, 5'd4, 3'd7); step();
    instr(5'd4, 5'd0, 2'b01, 5'd5, 3'd0); step(); step(); #1;
    n_cmp++;
    if (sc2 !== 4'hF || s_id[2] !== 1'b1) begin n_err++; $display("FAIL sat_hold: got %0h stall %b want f/1", sc2, s_id[2]); end
    rst = 1; step(); rst = 0; #1;
    n_cmp++;
    if (s_id[0] !== 1'b0 || sc2 !== 4'd0) begin n_err++; $display("FAIL mid_reset: stall %b ctr %0d want 0/0", s_id[0], sc2); end
    step(); idle();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 99) < 2); mp = ($urandom_range(0, 99) < 5); ext = ($urandom_range(0, 99) < 10);
      id_valid = ($urandom_range(0, 99) < 85); id_wr = ($urandom_range(0, 99) < 70);
      id_src = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))}; used = 2'($urandom);
      rd = 5'($urandom_range(0, 7)); lat = 3'($urandom);
      #1;
      for (int i = 0; i < 3; i++) begin
        logic h;
        logic [1:0] eh;
        logic [3:0] e_ctl, got;
        longint gsc;
        h = mhaz(i); eh = rst ? 2'b00 : mhz(i);
        e_ctl = {~rst & ~mp & (ext | h), ~rst & ~mp & (ext | h), ~rst & (mp | (~ext & h)), ~rst & mp};
        got = {s_if[i], s_id[i], bub[i], fl[i]};
        gsc = (i == 0) ? longint'(sc0) : (i == 1) ? longint'(sc1) : longint'(sc2);
        n_cmp++;
        if (got !== e_ctl || hs[i] !== eh || gsc != scm[i]) begin
          n_err++;
          $display("FAIL rand_u%0d cyc %0d: ctl %b hs %b ctr %0d want %b %b %0d", i, c, got, hs[i], gsc, e_ctl, eh, scm[i]);
        end
      end
      step();
    end
    rst = 0; idle();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      tk[i] = 0; scm[i] = 0;
      for (int r = 0; r < 32; r++) rdy[i][r] = 0;
    end
    idle(); rst = 1;
    @(posedge clk); #1;
    test_reset();
    test_load_use();
    test_ext_div();
    test_waw();
    test_mispredict();
    test_no_forward();
    test_saturate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
